// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  // Architectural zero register; writes to it are discarded.
  localparam logic [WB_AW-1:0] R0 = '0;

  // One queued multdiv result. valid=0 marks a killed (stale) entry.
  typedef struct packed {
    logic             valid;
    logic [WB_AW-1:0] rd;
    logic [WB_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Circular buffer for multdiv results with kill-by-address and
// age-ordered match vectors (index 0 = head/oldest) for forwarding.
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [AW-1:0]            i_push_rd,
  input  logic [DW-1:0]            i_push_data,
  input  logic                     i_push_killed,
  input  logic                     i_pop,
  input  logic                     i_kill,
  input  logic [AW-1:0]            i_kill_rd,
  input  logic [AW-1:0]            i_rs1,
  input  logic [AW-1:0]            i_rs2,
  output logic                     o_head_valid,
  output logic [AW-1:0]            o_head_rd,
  output logic [DW-1:0]            o_head_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [DEPTH-1:0]         o_match1,
  output logic [DEPTH-1:0]         o_match2,
  output logic [DEPTH-1:0][DW-1:0] o_age_data
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_valid;
  logic [AW-1:0]    r_rd   [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Storage update: kill old matches first, then pop clears the head,
  // then the new push lands (a push never targets the popped slot).
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_kill) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (r_rd[i] == i_kill_rd) r_valid[i] <= 1'b0;
        end
      end
      if (i_pop) begin
        r_valid[r_rptr] <= 1'b0;
        r_rptr          <= r_rptr + PW'(1);
      end
      if (i_push) begin
        r_valid[r_wptr] <= ~i_push_killed;
        r_rd[r_wptr]    <= i_push_rd;
        r_data[r_wptr]  <= i_push_data;
        r_wptr          <= r_wptr + PW'(1);
      end
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Age-ordered view; valid is cleared on pop, so valid implies occupied.
  always_comb begin
    o_match1   = '0;
    o_match2   = '0;
    o_age_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_age_data[i] = r_data[r_rptr + PW'(i)];
      o_match1[i]   = r_valid[r_rptr + PW'(i)] && (r_rd[r_rptr + PW'(i)] == i_rs1);
      o_match2[i]   = r_valid[r_rptr + PW'(i)] && (r_rd[r_rptr + PW'(i)] == i_rs2);
    end
  end

  assign o_head_valid = r_valid[r_rptr];
  assign o_head_rd    = r_rd[r_rptr];
  assign o_head_data  = r_data[r_rptr];
  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == CW'(DEPTH));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write-port feeder: pipeline writebacks take priority, queued
// multdiv results drain when the pipeline is idle; pending values are
// forwarded to both read ports.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_rd,
  input  logic [DW-1:0] pipe_data,
  input  logic          md_valid,
  input  logic [AW-1:0] md_rd,
  input  logic [DW-1:0] md_data,
  output logic          md_ready,
  output logic          ctrl_writeEnable,
  output logic [AW-1:0] ctrl_writeReg,
  output logic [DW-1:0] data_writeReg,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          fwd1_hit,
  output logic          fwd2_hit,
  output logic [DW-1:0] fwd1_data,
  output logic [DW-1:0] fwd2_data
);

  logic                     w_pipe_wr;
  logic                     w_push;
  logic                     w_push_killed;
  logic                     w_pop;
  logic                     w_head_valid;
  logic [AW-1:0]            w_head_rd;
  logic [DW-1:0]            w_head_data;
  logic                     w_empty;
  logic                     w_full;
  logic [DEPTH-1:0]         w_match1;
  logic [DEPTH-1:0]         w_match2;
  logic [DEPTH-1:0][DW-1:0] w_age_data;

  logic                     r_en;
  logic [AW-1:0]            r_addr;
  logic [DW-1:0]            r_data;

  assign w_pipe_wr     = pipe_we && (pipe_rd != AW'(R0));
  // Ready comes from the registered count only: no pop-to-push bypass.
  assign md_ready      = ~w_full;
  // r0 pushes complete the handshake but are dropped here.
  assign w_push        = md_valid && md_ready && (md_rd != AW'(R0));
  // Same-cycle pipeline write to the same register is the younger one.
  assign w_push_killed = w_pipe_wr && (md_rd == pipe_rd);
  // Head (valid or killed) leaves whenever the pipeline is not writing.
  assign w_pop         = ~w_pipe_wr && ~w_empty;

  wb_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .DW   (DW)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_rd    (md_rd),
    .i_push_data  (md_data),
    .i_push_killed(w_push_killed),
    .i_pop        (w_pop),
    .i_kill       (w_pipe_wr),
    .i_kill_rd    (pipe_rd),
    .i_rs1        (rs1),
    .i_rs2        (rs2),
    .o_head_valid (w_head_valid),
    .o_head_rd    (w_head_rd),
    .o_head_data  (w_head_data),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_match1     (w_match1),
    .o_match2     (w_match2),
    .o_age_data   (w_age_data)
  );

  // Output register: address/data hold their last value when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_pipe_wr) begin
      r_en   <= 1'b1;
      r_addr <= pipe_rd;
      r_data <= pipe_data;
    end else if (w_pop && w_head_valid) begin
      r_en   <= 1'b1;
      r_addr <= w_head_rd;
      r_data <= w_head_data;
    end else begin
      r_en   <= 1'b0;
    end
  end

  assign ctrl_writeEnable = r_en;
  assign ctrl_writeReg    = r_addr;
  assign data_writeReg    = r_data;

  // Forwarding, newest first: live pipeline write, output register,
  // then youngest FIFO match (later age index overrides earlier).
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (rs1 != AW'(R0)) begin
      if (w_pipe_wr && (pipe_rd == rs1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = pipe_data;
      end else if (r_en && (r_addr == rs1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = r_data;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_match1[i]) begin
            fwd1_hit  = 1'b1;
            fwd1_data = w_age_data[i];
          end
        end
      end
    end
    if (rs2 != AW'(R0)) begin
      if (w_pipe_wr && (pipe_rd == rs2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = pipe_data;
      end else if (r_en && (r_addr == rs2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = r_data;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (w_match2[i]) begin
            fwd2_hit  = 1'b1;
            fwd2_data = w_age_data[i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int DEPTH = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             pipe_we;
  logic [WB_AW-1:0] pipe_rd;
  logic [WB_DW-1:0] pipe_data;
  logic             md_valid;
  logic [WB_AW-1:0] md_rd;
  logic [WB_DW-1:0] md_data;
  logic             md_ready;
  logic             ctrl_writeEnable;
  logic [WB_AW-1:0] ctrl_writeReg;
  logic [WB_DW-1:0] data_writeReg;
  logic [WB_AW-1:0] rs1;
  logic [WB_AW-1:0] rs2;
  logic             fwd1_hit;
  logic             fwd2_hit;
  logic [WB_DW-1:0] fwd1_data;
  logic [WB_DW-1:0] fwd2_data;

  always #5 clock = ~clock;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(WB_AW), .DW(WB_DW)) dut (
    .clock           (clock),
    .reset           (reset),
    .pipe_we         (pipe_we),
    .pipe_rd         (pipe_rd),
    .pipe_data       (pipe_data),
    .md_valid        (md_valid),
    .md_rd           (md_rd),
    .md_data         (md_data),
    .md_ready        (md_ready),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .rs1             (rs1),
    .rs2             (rs2),
    .fwd1_hit        (fwd1_hit),
    .fwd2_hit        (fwd2_hit),
    .fwd1_data       (fwd1_data),
    .fwd2_data       (fwd2_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending multdiv results in age order plus the
  // register-file write currently presented.
  wb_entry_t        q[$];
  logic             m_en;
  logic [WB_AW-1:0] m_addr;
  logic [WB_DW-1:0] m_data;
  bit               m_known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [WB_DW:0] model_fwd(input logic [WB_AW-1:0] rs);
    if (rs == 0) return '0;
    if (pipe_we && pipe_rd != 0 && pipe_rd == rs) return {1'b1, pipe_data};
    if (m_en && m_addr == rs) return {1'b1, m_data};
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].valid && q[i].rd == rs) return {1'b1, q[i].data};
    return '0;
  endfunction

  // One clock: compare at the falling edge, advance the model, return
  // shortly after the rising edge so callers can check literals.
  task automatic step();
    logic [WB_DW:0] f1, f2;
    bit             pw, push;
    wb_entry_t      e;
    @(negedge clock);
    if (m_known) begin
      f1 = model_fwd(rs1);
      f2 = model_fwd(rs2);
      chk("md_ready",  32'(md_ready),         32'(q.size() < DEPTH));
      chk("we",        32'(ctrl_writeEnable), 32'(m_en));
      chk("wreg",      32'(ctrl_writeReg),    32'(m_addr));
      chk("wdata",     data_writeReg,         m_data);
      chk("fwd1_hit",  32'(fwd1_hit),         32'(f1[WB_DW]));
      chk("fwd1_data", fwd1_data,             f1[WB_DW-1:0]);
      chk("fwd2_hit",  32'(fwd2_hit),         32'(f2[WB_DW]));
      chk("fwd2_data", fwd2_data,             f2[WB_DW-1:0]);
    end
    if (reset) begin
      q.delete();
      m_en    = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_known = 1'b1;
    end else begin
      pw   = pipe_we && pipe_rd != 0;
      push = md_valid && (q.size() < DEPTH) && md_rd != 0;
      if (pw) begin
        for (int i = 0; i < q.size(); i++) begin
          if (q[i].rd == pipe_rd) begin
            e = q[i];
            e.valid = 1'b0;
            q[i] = e;
          end
        end
        m_en = 1'b1; m_addr = pipe_rd; m_data = pipe_data;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        if (e.valid) begin
          m_en = 1'b1; m_addr = e.rd; m_data = e.data;
        end else m_en = 1'b0;
      end else m_en = 1'b0;
      if (push) begin
        e.valid = !(pw && md_rd == pipe_rd);
        e.rd    = md_rd;
        e.data  = md_data;
        q.push_back(e);
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic pwe, input logic [WB_AW-1:0] prd, input logic [WB_DW-1:0] pd,
                       input logic mv, input logic [WB_AW-1:0] mrd, input logic [WB_DW-1:0] md);
    pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
    md_valid = mv; md_rd = mrd; md_data = md;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    repeat (DEPTH + 2) step();
  endtask

  initial begin
    reset = 1'b1; rs1 = '0; rs2 = '0;
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_we",    32'(ctrl_writeEnable), 32'd0);
    chk("rst_wreg",  32'(ctrl_writeReg),    32'd0);
    chk("rst_wdata", data_writeReg,         32'd0);
    chk("rst_ready", 32'(md_ready),         32'd1);

    // 1: single pipeline write, latency one cycle
    drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0);
    step();
    chk("t1_we",    32'(ctrl_writeEnable), 32'd1);
    chk("t1_wreg",  32'(ctrl_writeReg),    32'd5);
    chk("t1_wdata", data_writeReg,         32'hDEAD_BEEF);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    chk("t1_idle_we",   32'(ctrl_writeEnable), 32'd0);
    chk("t1_hold_wreg", 32'(ctrl_writeReg),    32'd5);

    // 2: fill FIFO while pops are blocked, then drain in order
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'd9, 32'h9999, 1'b1, 5'(k), 32'h100 + 32'(k));
      step();
      chk("t2_ready", 32'(md_ready), (k < 4) ? 32'd1 : 32'd0);
    end
    drive(1'b1, 5'd9, 32'h9999, 1'b1, 5'd6, 32'h666);
    step();
    chk("t2_full_ready", 32'(md_ready), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, '0, '0, 1'b0, '0, '0);
      step();
      chk("t2_we",    32'(ctrl_writeEnable), 32'd1);
      chk("t2_wreg",  32'(ctrl_writeReg),    32'(k));
      chk("t2_wdata", data_writeReg,         32'h100 + 32'(k));
    end
    step();
    chk("t2_end_we", 32'(ctrl_writeEnable), 32'd0);

    // 3: pipeline write kills a queued entry for the same register
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd7, 32'h11);
    step();
    drive(1'b1, 5'd7, 32'h22, 1'b0, '0, '0);
    step();
    chk("t3_we",    32'(ctrl_writeEnable), 32'd1);
    chk("t3_wreg",  32'(ctrl_writeReg),    32'd7);
    chk("t3_wdata", data_writeReg,         32'h22);
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    step();
    chk("t3_kill_we",    32'(ctrl_writeEnable), 32'd0);
    chk("t3_kill_wdata", data_writeReg,         32'h22);
    drain();

    // 4: forwarding returns the youngest pending value
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd3, 32'hA);
    step();
    drive(1'b1, 5'd9, 32'h9, 1'b1, 5'd3, 32'hB);
    step();
    drive(1'b1, 5'd9, 32'h9, 1'b0, '0, '0);
    rs1 = 5'd3; rs2 = 5'd0;
    #1;
    chk("t4_fwd1_hit",  32'(fwd1_hit),  32'd1);
    chk("t4_fwd1_data", fwd1_data,      32'hB);
    chk("t4_fwd2_hit",  32'(fwd2_hit),  32'd0);
    chk("t4_fwd2_data", fwd2_data,      32'd0);
    step();
    rs1 = '0;
    drain();

    // 5: writes to r0 never reach the register file
    for (int k = 0; k < DEPTH + 2; k++) begin
      drive(1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 32'hBAD);
      step();
      chk("t5_we",    32'(ctrl_writeEnable), 32'd0);
      chk("t5_ready", 32'(md_ready),         32'd1);
    end

    // 6: reset discards queued writes
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 5'd9, 32'h9, 1'b1, 5'(k + 10), 32'h300 + 32'(k));
      step();
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_we",    32'(ctrl_writeEnable), 32'd0);
    chk("t6_wreg",  32'(ctrl_writeReg),    32'd0);
    chk("t6_wdata", data_writeReg,         32'd0);
    chk("t6_ready", 32'(md_ready),         32'd1);
    for (int k = 0; k < DEPTH; k++) begin
      step();
      chk("t6_after_we", 32'(ctrl_writeEnable), 32'd0);
    end

    // Random traffic over a small register range to force collisions
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(99) == 0);
      drive($urandom_range(9) < 4, 5'($urandom_range(7)), $urandom,
            $urandom_range(1) == 1, 5'($urandom_range(7)), $urandom);
      rs1 = 5'($urandom_range(7));
      rs2 = 5'($urandom_range(7));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writeback-side feeder for the register file's single write port. It merges main-pipeline writebacks with out-of-order multdiv results.
- Drives the registered write address, data and enable that the register file's write-select decoder consumes.
- Buffers multdiv results in a small FIFO and kills stale entries.
- Forwards pending (not yet committed) values to the two read ports.

Parameters:
- DEPTH, 4, multdiv result FIFO entries (power of 2, ≥2)
- AW, 5, register address width
- DW, 32, data width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- pipe_we  in  1  main pipeline writeback valid
- pipe_rd  in  AW  pipeline destination register
- pipe_data  in  DW  pipeline writeback data
- md_valid  in  1  multdiv result valid
- md_rd  in  AW  multdiv destination register
- md_data  in  DW  multdiv result
- md_ready  out  1  FIFO can accept (count < DEPTH)
- ctrl_writeEnable  out  1  register file write enable (registered)
- ctrl_writeReg  out  AW  register file write address, feeds the decoder (registered)
- data_writeReg  out  DW  register file write data (registered)
- rs1, rs2  in  AW  read addresses under lookup
- fwd1_hit, fwd2_hit  out  1  pending value exists for rs1/rs2 (combinational)
- fwd1_data, fwd2_data  out  DW  newest pending value

Behaviour:
- Reset (synchronous, active-high):
  - FIFO emptied; count=0.
  - ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0.
  - md_ready=1 in the cycle after reset.
  - A reset mid-operation discards all queued and in-flight writes.
- Source select each cycle. Exactly one source goes to the output register, latency 1:
  1. If pipe_we && pipe_rd!=0, the pipeline write wins.
  2. Else if the FIFO head is valid (not killed), pop it and write it.
  3. Else if the FIFO head is killed, pop it silently; output enable=0.
  4. Else output enable=0.
  - Output address and data hold their last value when enable=0.
- Writes to r0: pipe_we with pipe_rd=0 is ignored. An md push with md_rd=0 is accepted (handshake completes) but not stored.
- md handshake:
  - A push occurs when md_valid && md_ready.
  - md_ready = (count<DEPTH), computed from registered count only. There is no pop-to-push bypass when full.
  - md_valid with md_ready=0: the producer holds its values; nothing is stored.
- Kill rule (WAW ordering):
  - A pipeline write to rd=X clears the valid bit of every FIFO entry with rd=X in the same cycle.
  - A same-cycle md push with md_rd=X is stored killed. The pipeline write is the younger write.
  - A killed entry still occupies its slot until it reaches the head.
- Simultaneous push and pop: allowed when not full. count stays constant and the pointers both advance.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Forwarding, for each rsN!=0, priority newest first:
  1. Current-cycle pipeline write.
  2. Output register (enable=1, same address).
  3. Youngest valid FIFO entry with matching rd.
  - hit=0 and data=0 if no match, or if rsN=0.

Decomposition:
- Shared package: AW/DW constants, the r0 constant, and a FIFO entry struct {valid, rd, data}.
- One natural sub-module, wb_fifo: circular buffer with push/pop/kill-by-address and a per-entry match vector.
- The arbiter, output register and forwarding mux stay in the top level.

Test Plan:
1. Reset, then pipe_we=1, rd=5, data=0xDEAD_BEEF → next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF. Following cycle enable=0.
2. Push 4 md results (rd=1..4) while pipe idle → written in order over 4 cycles. md_ready=0 only once count hits 4 with pops blocked (hold pipe_we=1, rd=9 continuously).
3. FIFO holds rd=7 (0x11) and pipe writes rd=7 (0x22) → FIFO entry killed. Only 0x22 is written to r7. The killed slot drains with enable=0.
4. Forwarding: FIFO holds rd=3 entries 0xA then 0xB, rs1=3 → fwd1_hit=1, fwd1_data=0xB. rs2=0 → fwd2_hit=0.
5. Writes to r0: pipe_we rd=0 and md push rd=0 → no write enable ever asserted, count unchanged, md handshake completes.
6. Reset asserted with 3 queued entries → next cycle count=0, enable=0, md_ready=1, and no queued writes appear afterward.
